rom_stream_ctrl: RTL and testbench
==================================

ROM_STREAM_CTRL -- requirements
Module: rom_stream_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, ROM data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, ROM address width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only when idle.
REQ-006 SHALL have port base_addr  input  ADDR_W  first ROM address of the burst; sampled with start.
REQ-007 SHALL have port count  input  ADDR_W+1  number of words to stream, 0..2^ADDR_W; sampled with start.
REQ-008 SHALL have port rom_addr  output  ADDR_W  registered address to the synchronous ROM.
REQ-009 SHALL have port rom_data  input  WIDTH  ROM read data, valid one cycle after rom_addr is registered.
REQ-010 SHALL have port out_data  output  WIDTH  streamed word.
REQ-011 SHALL have port out_valid  output  1  out_data/out_index/out_last are valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid and out_ready are both 1.
REQ-013 SHALL have port out_index  output  ADDR_W+1  word position within the burst, 0-based.
REQ-014 SHALL have port out_last  output  1  word is the final word of the burst.
REQ-015 SHALL have port busy  output  1  burst in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the final word transfers (or count=0 completes).

Function
REQ-017 SHALL implement states IDLE, FETCH and DRAIN; busy = 1 in FETCH and DRAIN.
REQ-018 IDLE: start=1 with count>0 SHALL latch base/count, register rom_addr<=base_addr, and enter FETCH (edge E0).
REQ-019 IDLE: start=1 with count=0 SHALL pulse done on the next cycle, remain IDLE, and produce no output.
REQ-020 start while busy SHALL be ignored; base_addr/count changes while busy SHALL have no effect.
REQ-021 Read path SHALL be fixed-latency: address registered at edge Ek; rom_data captured into the output buffer at edge Ek+2.
REQ-022 Output buffer SHALL be a 4-entry FIFO; out_valid = FIFO not empty; out_data/out_index/out_last come from the FIFO head.
REQ-023 A new address SHALL issue only when (FIFO occupancy + reads in flight) < 4, counting a same-cycle pop as freeing a slot.
REQ-024 With out_ready held at 1, the block SHALL sustain one word per cycle; first out_valid SHALL assert 2 cycles after E0.
REQ-025 Issued addresses SHALL be base_addr+i for i = 0..count-1, modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0).
REQ-026 FETCH SHALL move to DRAIN in the cycle after the count-th address issues; rom_addr SHALL hold its last value thereafter.
REQ-027 DRAIN SHALL return to IDLE on the edge where the out_last word transfers; done SHALL be 1 in the following cycle only.
REQ-028 out_valid SHALL never deassert without a transfer; out_data and out_index SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 FIFO SHALL never overflow or underflow under any out_ready pattern; dropped or duplicated words are forbidden.
REQ-030 out_last SHALL be 1 only for out_index = count-1.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE, empty FIFO and zero in-flight reads; rom_addr, out_valid, out_last, out_index, busy and done SHALL be 0; out_data SHALL be 0.
REQ-032 Reset mid-burst SHALL abandon the burst without a done pulse; ROM data returning after reset SHALL be discarded.
REQ-033 start SHALL be honoured on the first edge with rst=1.

Verification
REQ-034 base=0, count=10, out_ready=1, ROM at addr = results.hex -> 10 words on 10 consecutive cycles, first 2 cycles after start, index 0..9, last at 9, done one cycle later.
REQ-035 base=0xFE, count=4 -> addresses FE, FF, 00, 01 in order; out_data = mem[FE], mem[FF], mem[0], mem[1].
REQ-036 count=6, out_ready random 50% -> exactly 6 transfers in order, stable data while stalled, FIFO occupancy + in flight never > 4.
REQ-037 count=0 -> done pulses the next cycle; out_valid stays 0; busy stays 0.
REQ-038 rst=0 at word 3 of count=8, then start base=0x10, count=2 -> no done for the aborted burst; exactly mem[0x10], mem[0x11] output.
REQ-039 start pulsed again while busy with base=0x40 -> ignored; the original burst completes unchanged.

Source files
------------

// File: rtl/rom_stream_ctrl.sv
// Streams a burst of words from a synchronous ROM into a valid/ready port.
// A 4-entry output FIFO plus two in-flight read stages absorb back-pressure.
module rom_stream_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_e;

  localparam logic [ADDR_W:0]   ONE  = 1;
  localparam logic [ADDR_W-1:0] AONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   iss_q, iss_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic              v1_q, v2_q;
  logic [2:0]        occ_q;
  logic [1:0]        wr_q, rd_q;
  logic [WIDTH-1:0]  mem_q [4];

  logic              issue;
  logic              pop;
  logic              push;
  logic              head_last;
  logic              room;
  logic [3:0]        load;

  assign pop       = (occ_q != 3'd0) && out_ready;
  assign push      = v2_q;
  assign head_last = (idx_q == cnt_q - ONE);

  // FIFO words plus reads in flight; a same-cycle pop frees one slot
  assign load = {1'b0, occ_q} + {3'b0, v1_q} + {3'b0, v2_q};
  assign room = pop ? (load < 4'd5) : (load < 4'd4);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    if (pop) begin
      idx_d = idx_q + ONE;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            cnt_d   = count;
            iss_d   = ONE;
            idx_d   = '0;
            issue   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (iss_q == cnt_q) begin
          state_d = S_DRAIN;
        end else if (room) begin
          issue  = 1'b1;
          addr_d = addr_q + AONE;
          iss_d  = iss_q + ONE;
          if (iss_q + ONE == cnt_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      iss_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      occ_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      v1_q    <= issue;
      v2_q    <= v1_q;
      occ_q   <= occ_q + {2'b0, push} - {2'b0, pop};
      if (push) begin
        mem_q[wr_q] <= rom_data;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q <= rd_q + 2'd1;
      end
    end
  end

  assign rom_addr  = addr_q;
  assign out_valid = (occ_q != 3'd0);
  assign out_data  = mem_q[rd_q];
  assign out_index = idx_q;
  assign out_last  = out_valid && head_last;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Directed/random bench for rom_stream_ctrl against a word-list model
// built from the ROM contents, base address and count.
module tb_rom_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rom [256];
  int          errors;
  int          checks;

  rom_stream_ctrl #(.WIDTH(32), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".last"}, 64'(out_last), 64'd0);
  endtask

  // Caller is at #1 after a rising edge. abort_at >= 0 stops after that
  // many transfers without end-of-burst checks.
  task automatic run_burst(input logic [7:0] b, input logic [8:0] n,
                           input bit rnd, input bit inj, input int abort_at);
    int          k;
    int          cyc;
    int          first;
    bit          stalled;
    logic [31:0] hold_d;
    logic [8:0]  hold_i;
    logic [7:0]  ofs;
    logic [7:0]  a;
    k       = 0;
    cyc     = 0;
    first   = -1;
    stalled = 1'b0;
    hold_d  = '0;
    hold_i  = '0;
    start     = 1'b1;
    base_addr = b;
    count     = n;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 8'($urandom);
    count     = 9'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("addr_after_start", 64'(rom_addr), 64'(b));
    while (k < int'(n) && k != abort_at && cyc < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj && cyc == 3) begin
        start     = 1'b1;
        base_addr = 8'h40;
        count     = 9'd5;
      end else begin
        start = 1'b0;
      end
      if (done) chk("done_mid_burst", 64'(done), 64'd0);
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(hold_d));
        chk("stall_index", 64'(out_index), 64'(hold_i));
      end
      if (rnd && busy) begin
        ofs = rom_addr - b;
        if (int'(ofs) + 1 - k > 4)
          chk("outstanding_le4", 64'(int'(ofs) + 1 - k), 64'd4);
      end
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (out_ready) begin
          a = b + 8'(k);
          chk("data", 64'(out_data), 64'(rom[a]));
          chk("index", 64'(out_index), 64'(k));
          chk("last", 64'(out_last), 64'(k == int'(n) - 1));
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = out_data;
          hold_i  = out_index;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (k == abort_at) return;
    if (k < int'(n)) chk("burst_timeout", 64'(k), 64'(n));
    if (!rnd) begin
      chk("first_valid_cycle", 64'(first), 64'd2);
      chk("back_to_back", 64'(cyc), 64'(int'(n) + 2));
    end
    chk("done_pulse", 64'(done), 64'd1);
    idle_outs("after_last");
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_cleared", 64'(done), 64'd0);
    idle_outs("idle2");
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    idle_outs("rst");

    // start presented on the very first edge out of reset
    rst = 1'b1;
    run_burst(8'h00, 9'd10, 1'b0, 1'b0, -1);
    run_burst(8'hFE, 9'd4, 1'b0, 1'b0, -1);
    run_burst(8'h80, 9'd1, 1'b0, 1'b0, -1);

    for (int t = 0; t < 4; t++)
      run_burst(8'($urandom), 9'd6, 1'b1, 1'b0, -1);

    // count = 0: done only, no data
    start = 1'b1;
    count = 9'd0;
    base_addr = 8'h33;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    idle_outs("zero");
    @(posedge clk); #1;
    chk("zero_done_clr", 64'(done), 64'd0);
    idle_outs("zero2");

    run_burst(8'h00, 9'd10, 1'b0, 1'b1, -1);

    // abort a count=8 burst with word 3 at the head
    run_burst(8'h20, 9'd8, 1'b0, 1'b0, 3);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_addr", 64'(rom_addr), 64'd0);
    chk("abort_data", 64'(out_data), 64'd0);
    chk("abort_index", 64'(out_index), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    idle_outs("abort");
    rst = 1'b1;
    run_burst(8'h10, 9'd2, 1'b0, 1'b0, -1);

    run_burst(8'($urandom), 9'd256, 1'b1, 1'b0, -1);
    run_burst(8'($urandom), 9'd20, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
